mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL provide the following ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- addr  input  5  word address from the CPU address mux
- rd  input  1  read strobe from the CPU controller
- wr  input  1  write strobe from the CPU controller
- data_in  input  8  write data (the accumulator, driven while data_e is high)
- data_out  output  8  registered read data
- data_oe  output  1  high while data_out carries valid read data
- ready  output  1  high when a new rd/wr will be accepted this cycle
- err  output  1  sticky protocol-error flag
- prog_we  input  1  preload write strobe
- prog_addr  input  5  preload address
- prog_data  input  8  preload data

Function
REQ-002 The block SHALL hold a 32 x 8 storage array; contents SHALL NOT be altered by rst.
REQ-003 The FSM SHALL have states IDLE, WAIT and RESP; WAIT SHALL be reachable only when the configuration macro is defined.
REQ-004 In IDLE with rd=1, wr=0 and ready=1, the block SHALL latch addr and go to RESP, or to WAIT when wait states are enabled.
REQ-005 In RESP the block SHALL drive data_out = mem[latched addr] and data_oe=1 for exactly one cycle, then return to IDLE.
REQ-006 Read latency SHALL be one cycle from the rd sample edge to data_oe=1 without wait states, and two cycles with them.
REQ-007 data_out SHALL hold its last value after data_oe falls, until the next RESP.
REQ-008 In IDLE with wr=1, rd=0 and ready=1, mem[addr] SHALL take data_in at that clock edge, and the FSM SHALL go to WAIT when wait states are enabled, otherwise stay in IDLE.
REQ-009 A read issued in the cycle immediately after a write to the same address SHALL return the newly written value.
REQ-010 rd=1 and wr=1 in the same cycle SHALL perform neither access, SHALL set err=1, and SHALL leave the state unchanged.
REQ-011 rd or wr asserted while ready=0 SHALL be ignored and SHALL set err=1.
REQ-012 err SHALL remain set until rst.
REQ-013 prog_we=1 SHALL write prog_data to mem[prog_addr] only in IDLE with rd=0 and wr=0; otherwise it SHALL be dropped silently.
REQ-014 Addresses SHALL be a full 5-bit decode; address 31 SHALL be valid, with no wrap or aliasing.
REQ-015 Without wait states, ready SHALL be 1 in IDLE and 0 in RESP.
REQ-016 With wait states, ready SHALL be 1 only in IDLE.

Reset
REQ-017 When rst=1 at a clock edge: state SHALL become IDLE; data_out=8'h00; data_oe=0; err=0; ready=1 on the following cycle.
REQ-018 Reset asserted during WAIT or RESP SHALL abort the access with no data_oe pulse.
REQ-019 A write whose edge coincides with rst=1 SHALL NOT update memory.

Configuration
REQ-020 The macro MEM_RESPONDER_WAIT_STATE_EN, when defined, SHALL insert one WAIT cycle after each accepted rd or wr.
REQ-021 When MEM_RESPONDER_WAIT_STATE_EN is defined, ready SHALL be 0 during the WAIT cycle.
REQ-022 When MEM_RESPONDER_WAIT_STATE_EN is undefined, the WAIT state SHALL NOT be synthesized, and timing SHALL match the CPU controller's single-cycle rd/T1 capture.

Verification
REQ-023 Preload and read: prog_we with addr 5 = 8'hA7, then rd with addr=5 -> data_oe=1 and data_out=8'hA7 one cycle later (two cycles with wait states).
REQ-024 Write then read: wr with addr=31 and data_in=8'h3C, next cycle rd with addr=31 -> data_out=8'h3C, err=0.
REQ-025 Collision: rd=1 and wr=1 with addr=2 -> mem[2] unchanged, data_oe stays 0, err=1 until rst.
REQ-026 Reset mid-read: rd with addr=7, rst=1 on the next edge -> no data_oe pulse, data_out=8'h00, state IDLE, memory intact.
REQ-027 Wait states (macro defined): rd with addr=1, then a second rd on the next cycle -> second rd ignored and err=1; first read completes with data_oe after two cycles.
REQ-028 Preload blocked: prog_we=1 while rd=1 with addr=9 -> preload dropped and the prior mem[9] is returned.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 32x8 CPU memory responder with preload port
// Optional one-cycle wait state after each accepted access: MEM_RESPONDER_WAIT_STATE_EN
module mem_responder (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       ready,
  output logic       err,
  input  logic       prog_we,
  input  logic [4:0] prog_addr,
  input  logic [7:0] prog_data
);

`ifdef MEM_RESPONDER_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, WAIT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1} state_t;
`endif

  state_t     state;
  logic [7:0] mem [32];
  logic       oe_q;
  logic       collide;
  logic       stray;
  logic       rd_go;
  logic       wr_go;
  logic       prog_go;

`ifdef MEM_RESPONDER_WAIT_STATE_EN
  logic [4:0] lat_addr;
  logic       rd_pend;
`endif

  // ready is high exactly when the FSM sits in IDLE, so it doubles as the accept gate
  assign collide = rd & wr;
  assign stray   = (rd | wr) & ~ready;
  assign rd_go   = rd & ~wr & ready;
  assign wr_go   = wr & ~rd & ready;
  assign prog_go = prog_we & ~rd & ~wr & (state == IDLE);

  // a reset arriving while a response is on the bus suppresses the strobe immediately
  assign data_oe = oe_q & ~rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_go) begin
        mem[addr] <= data_in;
      end else if (prog_go) begin
        mem[prog_addr] <= prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_out <= 8'h00;
      oe_q     <= 1'b0;
      ready    <= 1'b1;
      err      <= 1'b0;
`ifdef MEM_RESPONDER_WAIT_STATE_EN
      lat_addr <= 5'd0;
      rd_pend  <= 1'b0;
`endif
    end else begin
      oe_q <= 1'b0;
      if (collide || stray) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (rd_go) begin
            ready <= 1'b0;
`ifdef MEM_RESPONDER_WAIT_STATE_EN
            state    <= WAIT;
            lat_addr <= addr;
            rd_pend  <= 1'b1;
`else
            state    <= RESP;
            data_out <= mem[addr];
            oe_q     <= 1'b1;
`endif
          end else if (wr_go) begin
`ifdef MEM_RESPONDER_WAIT_STATE_EN
            state   <= WAIT;
            ready   <= 1'b0;
            rd_pend <= 1'b0;
`else
            state   <= IDLE;
`endif
          end
        end
`ifdef MEM_RESPONDER_WAIT_STATE_EN
        WAIT: begin
          if (rd_pend) begin
            state    <= RESP;
            data_out <= mem[lat_addr];
            oe_q     <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
`endif
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
// Directed scenarios followed by randomized traffic against a transaction-level model.
module tb_mem_responder;

`ifdef MEM_RESPONDER_WAIT_STATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] addr = '0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       data_oe;
  logic       ready;
  logic       err;
  logic       prog_we = 1'b0;
  logic [4:0] prog_addr = '0;
  logic [7:0] prog_data = '0;

  mem_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .ready(ready), .err(err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_mem [32];
  int         busy = 0;
  logic       m_err = 1'b0;
  logic [7:0] exp_last = 8'h00;
  int         cyc = 0;
  int         npass = 0;
  int         ntot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Transaction-level model: busy counts cycles the responder stays unavailable.
  task automatic model_edge(input bit r, input bit rdi, input bit wri, input logic [4:0] a,
                            input logic [7:0] d, input bit pw, input logic [4:0] pa,
                            input logic [7:0] pd);
    bit rdy;
    bit acc;
    rdy = (busy == 0);
    acc = 1'b0;
    if (r) begin
      busy = 0;
      m_err = 1'b0;
      exp_last = 8'h00;
      return;
    end
    if (rdi && wri) m_err = 1'b1;
    else if ((rdi || wri) && !rdy) m_err = 1'b1;
    else if (rdi) begin
      exp_q.push_back('{data: m_mem[a], due: cyc + WS});
      busy = 1 + WS;
      acc = 1'b1;
    end else if (wri) begin
      m_mem[a] = d;
      busy = WS;
      acc = 1'b1;
    end else if (pw && rdy) begin
      m_mem[pa] = pd;
    end
    if (!acc && busy > 0) busy--;
  endtask

  task automatic do_cycle(input bit r, input bit rdi, input bit wri, input logic [4:0] a,
                          input logic [7:0] d, input bit pw, input logic [4:0] pa,
                          input logic [7:0] pd);
    rst = r; rd = rdi; wr = wri; addr = a; data_in = d;
    prog_we = pw; prog_addr = pa; prog_data = pd;
    if (r) exp_q.delete();
    @(negedge clk);
    if (cyc > 0) begin
      chk("ready", {31'd0, ready}, {31'd0, busy == 0});
      chk("err", {31'd0, err}, {31'd0, m_err});
    end
    @(posedge clk);
    cyc++;
    model_edge(r, rdi, wri, a, d, pw, pa, pd);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (rst) begin
          chk("oe_in_reset", {31'd0, data_oe}, 32'd0);
        end else if (data_oe === 1'b1) begin
          if (exp_q.size() == 0) begin
            ntot++;
            $display("FAIL spurious_oe: got data_oe=1 data_out=%0h expected no response (cycle %0d)", data_out, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data", {24'd0, data_out}, {24'd0, e.data});
            chk("rd_latency", cyc, e.due);
            exp_last = e.data;
          end
        end else begin
          chk("hold", {24'd0, data_out}, {24'd0, exp_last});
          if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            ntot++;
            $display("FAIL missing_oe: got data_oe=%b expected response %0h due cycle %0d (cycle %0d)", data_oe, e.data, e.due, cyc);
          end
        end
      end
    end
  end

  initial begin
    int op;
    logic [4:0] a;
    do_cycle(1'b1, 0, 0, 5'd0, 8'd0, 0, 5'd0, 8'd0);
    do_cycle(1'b1, 0, 0, 5'd0, 8'd0, 0, 5'd0, 8'd0);
    idle(1);
    for (int i = 0; i < 32; i++)
      do_cycle(1'b0, 0, 0, 5'd0, 8'd0, 1'b1, i[4:0], 8'($urandom));
    // preload then read
    do_cycle(1'b0, 0, 0, 5'd0, 8'd0, 1'b1, 5'd5, 8'hA7);
    do_cycle(1'b0, 1, 0, 5'd5, 8'd0, 0, 5'd0, 8'd0);
    idle(3);
    // write then read at top address
    do_cycle(1'b0, 0, 1, 5'd31, 8'h3C, 0, 5'd0, 8'd0);
    if (WS != 0) idle(1);
    do_cycle(1'b0, 1, 0, 5'd31, 8'd0, 0, 5'd0, 8'd0);
    idle(3);
    // collision, then read back unchanged location
    do_cycle(1'b0, 1, 1, 5'd2, 8'h55, 0, 5'd0, 8'd0);
    idle(2);
    do_cycle(1'b0, 1, 0, 5'd2, 8'd0, 0, 5'd0, 8'd0);
    idle(3);
    do_cycle(1'b1, 0, 0, 5'd0, 8'd0, 0, 5'd0, 8'd0);
    idle(1);
    // reset mid-read, memory must survive
    do_cycle(1'b0, 1, 0, 5'd7, 8'd0, 0, 5'd0, 8'd0);
    do_cycle(1'b1, 0, 0, 5'd0, 8'd0, 0, 5'd0, 8'd0);
    idle(2);
    do_cycle(1'b0, 1, 0, 5'd7, 8'd0, 0, 5'd0, 8'd0);
    idle(3);
    // preload colliding with a read is dropped
    do_cycle(1'b0, 1, 0, 5'd9, 8'd0, 1'b1, 5'd9, 8'hEE);
    idle(3);
    do_cycle(1'b0, 1, 0, 5'd9, 8'd0, 0, 5'd0, 8'd0);
    idle(3);
    // back-to-back reads: second is refused
    do_cycle(1'b0, 1, 0, 5'd1, 8'd0, 0, 5'd0, 8'd0);
    do_cycle(1'b0, 1, 0, 5'd3, 8'd0, 0, 5'd0, 8'd0);
    idle(4);
    do_cycle(1'b1, 0, 0, 5'd0, 8'd0, 0, 5'd0, 8'd0);
    idle(1);
    for (int i = 0; i < 600; i++) begin
      op = $urandom_range(0, 99);
      a = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
      if (op < 2)
        do_cycle(1'b1, $urandom_range(0, 1), 0, a, 8'($urandom), 0, 5'd0, 8'd0);
      else if (op < 35)
        do_cycle(1'b0, 1, 0, a, 8'd0, $urandom_range(0, 3) == 0, 5'($urandom), 8'($urandom));
      else if (op < 60)
        do_cycle(1'b0, 0, 1, a, 8'($urandom), $urandom_range(0, 3) == 0, 5'($urandom), 8'($urandom));
      else if (op < 63)
        do_cycle(1'b0, 1, 1, a, 8'($urandom), 0, 5'd0, 8'd0);
      else if (op < 78)
        do_cycle(1'b0, 0, 0, 5'd0, 8'd0, 1'b1, a, 8'($urandom));
      else
        idle(1);
    end
    idle(5);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
